// File: rtl/axis_checker_arbiter.sv
// Round-robin arbiter sharing one downstream AXIS consumer among PORTS producers.
// Grants last up to BURST beats; accepted beats pass through one registered, id-tagged stage.
module axis_checker_arbiter #(
  parameter int DATA_WIDTH = 10,
  parameter int PORTS      = 4,
  parameter int BURST      = 16,
  localparam int ID_WIDTH  = (PORTS > 1) ? $clog2(PORTS) : 1,
  localparam int CNT_W     = $clog2(BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS-1:0]              input_valid,
  input  logic [PORTS*DATA_WIDTH-1:0]   input_data,
  output logic [PORTS-1:0]              input_ready,
  output logic                          output_valid,
  output logic [DATA_WIDTH-1:0]         output_data,
  output logic [ID_WIDTH-1:0]           output_id,
  output logic                          output_last,
  input  logic                          output_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q;
  logic [ID_WIDTH-1:0] ptr_q;
  logic [ID_WIDTH-1:0] gnt_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [ID_WIDTH-1:0]   sel_d;
  logic [ID_WIDTH-1:0]   ptr_d;
  logic [CNT_W-1:0]      cnt_d;
  logic                  req_any;
  logic                  slot_free;
  logic                  gnt_valid;
  logic                  in_hs;
  logic                  last_beat;
  logic [DATA_WIDTH-1:0] gnt_data;

  // Walk downward so the lowest rotated offset with a request wins.
  always_comb begin
    int idx;
    idx     = 0;
    sel_d   = ptr_q;
    req_any = 1'b0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (input_valid[ID_WIDTH'(idx)]) begin
        sel_d   = ID_WIDTH'(idx);
        req_any = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_data  = '0;
    gnt_valid = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (gnt_q == ID_WIDTH'(p)) begin
        gnt_data  = input_data[p*DATA_WIDTH +: DATA_WIDTH];
        gnt_valid = input_valid[p];
      end
    end
  end

  assign slot_free = !output_valid || output_ready;
  assign in_hs     = (state_q == LOCKED) && slot_free && gnt_valid;
  assign last_beat = (cnt_q == CNT_W'(BURST - 1));
  assign ptr_d     = (gnt_q == ID_WIDTH'(PORTS - 1)) ? '0 : gnt_q + 1'b1;
  assign cnt_d     = cnt_q + 1'b1;

  always_comb begin
    input_ready = '0;
    if (state_q == LOCKED) input_ready[gnt_q] = slot_free;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      cnt_q        <= '0;
      output_valid <= 1'b0;
      output_data  <= '0;
      output_id    <= '0;
      output_last  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            gnt_q   <= sel_d;
            cnt_q   <= '0;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (in_hs) begin
            cnt_q <= cnt_d;
            if (last_beat) begin
              state_q <= IDLE;
              ptr_q   <= ptr_d;
            end
          end else if (slot_free) begin
            // Ready offered but no valid: the producer has paused, so yield.
            state_q <= IDLE;
            ptr_q   <= ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (in_hs) begin
        output_valid <= 1'b1;
        output_data  <= gnt_data;
        output_id    <= gnt_q;
        output_last  <= last_beat;
      end else if (output_ready) begin
        output_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_checker_arbiter.sv
// Bench for axis_checker_arbiter: a 4-port/BURST=4 instance and a 3-port/BURST=1 instance.
module tb_axis_checker_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [3:0]  a_valid = '0;
  logic [39:0] a_data  = '0;
  logic [3:0]  a_ready;
  logic        a_ov, a_ol;
  logic [9:0]  a_od;
  logic [1:0]  a_oid;
  logic        a_ordy = 1'b1;

  logic [2:0]  b_valid = '0;
  logic [29:0] b_data  = '0;
  logic [2:0]  b_ready;
  logic        b_ov, b_ol;
  logic [9:0]  b_od;
  logic [1:0]  b_oid;
  logic        b_ordy = 1'b1;

  axis_checker_arbiter #(.DATA_WIDTH(10), .PORTS(4), .BURST(4)) dut_a (
    .clk(clk), .rst(rst),
    .input_valid(a_valid), .input_data(a_data), .input_ready(a_ready),
    .output_valid(a_ov), .output_data(a_od), .output_id(a_oid),
    .output_last(a_ol), .output_ready(a_ordy)
  );

  axis_checker_arbiter #(.DATA_WIDTH(10), .PORTS(3), .BURST(1)) dut_b (
    .clk(clk), .rst(rst),
    .input_valid(b_valid), .input_data(b_data), .input_ready(b_ready),
    .output_valid(b_ov), .output_data(b_od), .output_id(b_oid),
    .output_last(b_ol), .output_ready(b_ordy)
  );

  typedef struct {
    logic [9:0] d;
    logic [1:0] id;
    logic       last;
    int         c;
  } beat_t;

  logic [9:0] pq   [4][$];
  logic [9:0] expq [4][$];
  beat_t      abeats[$];
  beat_t      bbeats[$];
  int         bcnt[3];
  int         ordy_mode = 0;
  int         pat_idx   = 0;
  bit         drop_on_stall = 1'b0;
  bit         pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Producer/consumer model for instance a: per-port queues feed the inputs,
  // accepted beats are popped, delivered beats are logged with their cycle.
  always begin
    beat_t bt;
    @(negedge clk);
    cyc++;
    case (ordy_mode)
      0: a_ordy = 1'b1;
      1: begin a_ordy = pat[pat_idx % 4]; pat_idx++; end
      2: a_ordy = 1'($urandom & 1);
      default: a_ordy = 1'b0;
    endcase
    for (int p = 0; p < 4; p++) begin
      if (pq[p].size() > 0 && !(drop_on_stall && a_ov && !a_ordy)) begin
        a_valid[p] = 1'b1;
        a_data[p*10 +: 10] = pq[p][0];
      end else begin
        a_valid[p] = 1'b0;
      end
    end
    #1;
    checks++;
    if ($countones(a_ready) > 1) begin
      errors++;
      $display("FAIL ready_onehot_a: input_ready=%b, required at most one bit high", a_ready);
    end
    for (int p = 0; p < 4; p++)
      if (a_valid[p] && a_ready[p]) void'(pq[p].pop_front());
    if (a_ov && a_ordy) begin
      bt.d = a_od; bt.id = a_oid; bt.last = a_ol; bt.c = cyc;
      abeats.push_back(bt);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < 4; p++) pq[p].delete();
    ordy_mode = 0;
    drop_on_stall = 1'b0;
    pat_idx = 0;
    b_valid = '0;
    b_ordy = 1'b1;
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    abeats.delete();
    bbeats.delete();
  endtask

  task automatic wait_a(input int n, input int budget, output bit ok);
    int k = 0;
    while (abeats.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (abeats.size() >= n);
  endtask

  task automatic b_run(input logic [2:0] mask, input int ncyc);
    beat_t bt;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      b_valid = mask;
      for (int p = 0; p < 3; p++) b_data[p*10 +: 10] = 10'(p * 100 + bcnt[p]);
      #1;
      checks++;
      if ($countones(b_ready) > 1) begin
        errors++;
        $display("FAIL ready_onehot_b: input_ready=%b, required at most one bit high", b_ready);
      end
      for (int p = 0; p < 3; p++)
        if (b_valid[p] && b_ready[p]) bcnt[p]++;
      if (b_ov && b_ordy) begin
        bt.d = b_od; bt.id = b_oid; bt.last = b_ol; bt.c = cyc;
        bbeats.push_back(bt);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (a_ov !== 1'b0 || a_od !== 10'd0 || a_oid !== 2'd0 || a_ol !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_a: valid=%b data=%h id=%0d last=%b, required all zero", a_ov, a_od, a_oid, a_ol);
    end
    checks++;
    if (a_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_ready_a: input_ready=%b, required 0000", a_ready);
    end
    checks++;
    if (b_ov !== 1'b0 || b_ready !== 3'b0 || b_od !== 10'd0) begin
      errors++;
      $display("FAIL reset_b: valid=%b ready=%b data=%h, required zero", b_ov, b_ready, b_od);
    end
  endtask

  task automatic test_contention();
    bit ok;
    int exp_id, exp_seq, exp_gap;
    do_reset();
    for (int p = 0; p < 4; p++)
      for (int s = 0; s < 8; s++) pq[p].push_back(10'((p << 8) | s));
    wait_a(20, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL contention_timeout: beats=%0d, required 20", abeats.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        exp_id  = (i / 4) % 4;
        exp_seq = (i / 16) * 4 + i % 4;
        checks++;
        if (abeats[i].d !== 10'((exp_id << 8) | exp_seq) || abeats[i].id !== 2'(exp_id) ||
            abeats[i].last !== 1'(i % 4 == 3)) begin
          errors++;
          $display("FAIL contention_beat%0d: data=%h id=%0d last=%b, required data=%h id=%0d last=%b",
                   i, abeats[i].d, abeats[i].id, abeats[i].last,
                   10'((exp_id << 8) | exp_seq), exp_id, (i % 4 == 3));
        end
        if (i > 0) begin
          exp_gap = (i % 4 == 0) ? 2 : 1;
          checks++;
          if (abeats[i].c - abeats[i-1].c != exp_gap) begin
            errors++;
            $display("FAIL contention_spacing%0d: gap=%0d cycles, required %0d",
                     i, abeats[i].c - abeats[i-1].c, exp_gap);
          end
        end
      end
    end
  endtask

  task automatic test_gap_release();
    bit ok;
    int k = 0;
    logic [9:0] exp_d  [6] = '{10'h200, 10'h201, 10'h300, 10'h301, 10'h000, 10'h001};
    int         exp_id [6] = '{2, 2, 3, 3, 0, 0};
    do_reset();
    pq[2].push_back(10'h200);
    pq[2].push_back(10'h201);
    while (pq[2].size() == 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    pq[3].push_back(10'h300); pq[3].push_back(10'h301);
    pq[0].push_back(10'h000); pq[0].push_back(10'h001);
    wait_a(6, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL gap_timeout: beats=%0d, required 6", abeats.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (abeats[i].d !== exp_d[i] || abeats[i].id !== 2'(exp_id[i]) || abeats[i].last !== 1'b0) begin
          errors++;
          $display("FAIL gap_beat%0d: data=%h id=%0d last=%b, required data=%h id=%0d last=0",
                   i, abeats[i].d, abeats[i].id, abeats[i].last, exp_d[i], exp_id[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [9:0] exp_d  [6] = '{10'd5, 10'd6, 10'd7, 10'd8, 10'h100, 10'h101};
    int         exp_id [6] = '{0, 0, 0, 0, 1, 1};
    logic       exp_l  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    ordy_mode = 1;
    drop_on_stall = 1'b1;
    for (int v = 5; v <= 8; v++) pq[0].push_back(10'(v));
    pq[1].push_back(10'h100);
    pq[1].push_back(10'h101);
    wait_a(6, 200, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || abeats.size() != 6) begin
      errors++;
      $display("FAIL backpressure_count: beats=%0d, required 6", abeats.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (abeats[i].d !== exp_d[i] || abeats[i].id !== 2'(exp_id[i]) || abeats[i].last !== exp_l[i]) begin
          errors++;
          $display("FAIL backpressure_beat%0d: data=%h id=%0d last=%b, required data=%h id=%0d last=%b",
                   i, abeats[i].d, abeats[i].id, abeats[i].last, exp_d[i], exp_id[i], exp_l[i]);
        end
      end
    end
    drop_on_stall = 1'b0;
    ordy_mode = 0;
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int k = 0;
    do_reset();
    ordy_mode = 3;
    for (int v = 0; v < 4; v++) pq[1].push_back(10'(10'h111 + v));
    while (a_ov !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (a_ov !== 1'b1 || a_oid !== 2'd1 || a_od !== 10'h111) begin
      errors++;
      $display("FAIL midreset_setup: valid=%b id=%0d data=%h, required valid=1 id=1 data=111", a_ov, a_oid, a_od);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_ov !== 1'b0 || a_od !== 10'd0 || a_oid !== 2'd0 || a_ol !== 1'b0 || a_ready !== 4'b0) begin
      errors++;
      $display("FAIL midreset_async: valid=%b data=%h id=%0d last=%b ready=%b, required all zero",
               a_ov, a_od, a_oid, a_ol, a_ready);
    end
    for (int p = 0; p < 4; p++) pq[p].delete();
    ordy_mode = 0;
    @(negedge clk);
    #3 rst = 1'b0;
    abeats.delete();
    pq[3].push_back(10'h3AA);
    wait_a(1, 20, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || abeats.size() != 1) begin
      errors++;
      $display("FAIL midreset_after_count: beats=%0d, required 1", abeats.size());
    end else begin
      checks++;
      if (abeats[0].id !== 2'd3 || abeats[0].d !== 10'h3AA) begin
        errors++;
        $display("FAIL midreset_after_beat: id=%0d data=%h, required id=3 data=3aa", abeats[0].id, abeats[0].d);
      end
    end
  endtask

  task automatic test_random();
    int n, total, k, prev_ok;
    for (int round = 0; round < 3; round++) begin
      do_reset();
      ordy_mode = 2;
      drop_on_stall = 1'b1;
      total = 0;
      for (int p = 0; p < 4; p++) begin
        expq[p].delete();
        n = $urandom_range(0, 12);
        for (int s = 0; s < n; s++) begin
          logic [9:0] v;
          v = 10'($urandom);
          pq[p].push_back(v);
          expq[p].push_back(v);
        end
        total += n;
      end
      k = 0;
      while ((pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() > 0 || a_ov) && k < 3000) begin
        @(negedge clk);
        k++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (abeats.size() != total) begin
        errors++;
        $display("FAIL random_count_r%0d: beats=%0d, required %0d", round, abeats.size(), total);
      end
      for (int i = 0; i < abeats.size(); i++) begin
        checks++;
        if (expq[abeats[i].id].size() == 0) begin
          errors++;
          $display("FAIL random_extra_r%0d: beat %0d from port %0d data=%h, required none", round, i, abeats[i].id, abeats[i].d);
        end else if (abeats[i].d !== expq[abeats[i].id][0]) begin
          errors++;
          $display("FAIL random_order_r%0d: beat %0d port %0d data=%h, required %h",
                   round, i, abeats[i].id, abeats[i].d, expq[abeats[i].id][0]);
          void'(expq[abeats[i].id].pop_front());
        end else begin
          void'(expq[abeats[i].id].pop_front());
        end
        if (abeats[i].last) begin
          prev_ok = (i >= 3) && abeats[i-1].id == abeats[i].id &&
                    abeats[i-2].id == abeats[i].id && abeats[i-3].id == abeats[i].id;
          checks++;
          if (!prev_ok) begin
            errors++;
            $display("FAIL random_last_r%0d: beat %0d flagged last without 4 same-port beats", round, i);
          end
        end
      end
    end
    drop_on_stall = 1'b0;
    ordy_mode = 0;
  endtask

  task automatic test_single_wrap();
    int e[3];
    int id;
    do_reset();
    for (int p = 0; p < 3; p++) bcnt[p] = 0;
    b_run(3'b100, 20);
    checks++;
    if (bbeats.size() < 8) begin
      errors++;
      $display("FAIL single_count: beats=%0d, required at least 8", bbeats.size());
    end
    for (int i = 0; i < bbeats.size(); i++) begin
      checks++;
      if (bbeats[i].id !== 2'd2 || bbeats[i].last !== 1'b1 || bbeats[i].d !== 10'(200 + i)) begin
        errors++;
        $display("FAIL single_beat%0d: id=%0d last=%b data=%0d, required id=2 last=1 data=%0d",
                 i, bbeats[i].id, bbeats[i].last, bbeats[i].d, 200 + i);
      end
      if (i > 0) begin
        checks++;
        if (bbeats[i].c - bbeats[i-1].c != 2) begin
          errors++;
          $display("FAIL single_spacing%0d: gap=%0d, required 2", i, bbeats[i].c - bbeats[i-1].c);
        end
      end
    end
    b_run(3'b000, 4);
    bbeats.delete();
    for (int p = 0; p < 3; p++) e[p] = bcnt[p];
    b_run(3'b111, 13);
    checks++;
    if (bbeats.size() < 5) begin
      errors++;
      $display("FAIL wrap_count: beats=%0d, required at least 5", bbeats.size());
    end
    for (int i = 0; i < bbeats.size(); i++) begin
      id = i % 3;
      checks++;
      if (bbeats[i].id !== 2'(id) || bbeats[i].d !== 10'(id * 100 + e[id])) begin
        errors++;
        $display("FAIL wrap_beat%0d: id=%0d data=%0d, required id=%0d data=%0d",
                 i, bbeats[i].id, bbeats[i].d, id, id * 100 + e[id]);
      end
      e[id]++;
    end
    b_valid = '0;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_gap_release();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    test_single_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
